pwm_fade_bank: RTL and testbench



---
 rtl/pwm_fade_pkg.sv | 30 +++
 rtl/pwm_fade_channel.sv | 45 ++++
 rtl/pwm_fade_bank.sv | 116 +++++++++++
 tb/tb_pwm_fade_bank.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_fade_pkg.sv
// Shared constants for the PWM fade bank: register map, CTRL bit positions
// and byte-lane helpers used by the register decode and the channels.
package pwm_fade_pkg;

  localparam logic [7:0] ADDR_TGT_LO = 8'h00;
  localparam logic [7:0] ADDR_TGT_HI = 8'h20;
  localparam logic [7:0] ADDR_CUR    = 8'h40;
  localparam logic [7:0] ADDR_CTRL   = 8'h60;
  localparam logic [7:0] ADDR_PRESC  = 8'h61;
  localparam logic [7:0] ADDR_INV_LO = 8'h62;
  localparam logic [7:0] ADDR_INV_HI = 8'h63;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_FADE_EN = 1;

  // Registers wider than a byte are accessed as a low/high byte pair.
  function automatic logic [7:0] get_byte(input logic [15:0] v, input logic hi);
    return hi ? v[15:8] : v[7:0];
  endfunction

  function automatic logic [15:0] set_byte(input logic [15:0] v, input logic hi,
                                           input logic [7:0] b);
    logic [15:0] r;
    r = v;
    if (hi) r[15:8] = b;
    else    r[7:0]  = b;
    return r;
  endfunction

endpackage

// File: rtl/pwm_fade_channel.sv
// One PWM channel: target and live duty registers, fade stepping and the
// registered PWM output compared against the shared period counter.
module pwm_fade_channel
  import pwm_fade_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [7:0]       wdata,
  input  logic             boundary,
  input  logic             step,
  input  logic             fade_en,
  input  logic             en,
  input  logic             inv,
  input  logic [PWM_W-1:0] ctr,
  output logic             pwm,
  output logic [PWM_W-1:0] tgt,
  output logic [PWM_W-1:0] cur
);

  // cur only moves on the boundary edge, so the duty never changes mid-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt <= '0;
      cur <= '0;
      pwm <= 1'b0;
    end else begin
      if (wr_lo || wr_hi)
        tgt <= PWM_W'(set_byte(16'(tgt), wr_hi, wdata));
      if (boundary) begin
        if (!fade_en)
          cur <= tgt;
        else if (step) begin
          if (cur < tgt)      cur <= cur + PWM_W'(1);
          else if (cur > tgt) cur <= cur - PWM_W'(1);
        end
      end
      pwm <= en & ((ctr < cur) ^ inv);
    end
  end

endmodule

// File: rtl/pwm_fade_bank.sv
// NCH-channel PWM bank with glitch-free duty updates and a linear fade engine,
// programmed through a byte-wide register interface.
module pwm_fade_bank
  import pwm_fade_pkg::*;
#(
  parameter int NCH     = 8,
  parameter int PWM_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wen,
  input  logic [7:0]     addr,
  input  logic [7:0]     wdata,
  output logic [7:0]     rdata,
  output logic [NCH-1:0] pwm_o,
  output logic           period_start
);

  localparam logic [PWM_W-1:0] CTR_LAST = PWM_W'((2 ** PWM_W) - 2);

  logic [PWM_W-1:0]   ctr;
  logic [PRESC_W-1:0] pcnt;
  logic [PRESC_W-1:0] presc_q;
  logic [1:0]         ctrl_q;
  logic [NCH-1:0]     inv_q;
  logic [NCH-1:0]     wr_lo;
  logic [NCH-1:0]     wr_hi;
  logic [PWM_W-1:0]   tgt_arr [NCH];
  logic [PWM_W-1:0]   cur_arr [NCH];
  logic               boundary;
  logic               fade_en;
  logic               step;

  assign boundary = (ctr == CTR_LAST);
  assign fade_en  = ctrl_q[CTRL_FADE_EN];
  assign step     = boundary & fade_en & (pcnt == presc_q);

  always_comb begin
    wr_lo = '0;
    wr_hi = '0;
    for (int i = 0; i < NCH; i++) begin
      if (wen && addr[7:5] == ADDR_TGT_LO[7:5] && addr[4:0] == 5'(i))
        wr_lo[i] = 1'b1;
      if (PWM_W > 8 && wen && addr[7:5] == ADDR_TGT_HI[7:5] && addr[4:0] == 5'(i))
        wr_hi[i] = 1'b1;
    end
  end

  // The counter free-runs independently of EN; pcnt advances only on boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr          <= '0;
      pcnt         <= '0;
      period_start <= 1'b0;
    end else begin
      ctr          <= boundary ? '0 : ctr + PWM_W'(1);
      period_start <= (ctr == '0);
      if (boundary && fade_en)
        pcnt <= (pcnt == presc_q) ? '0 : pcnt + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      presc_q <= '0;
      inv_q   <= '0;
    end else if (wen) begin
      if (addr == ADDR_CTRL)  ctrl_q  <= wdata[1:0];
      if (addr == ADDR_PRESC) presc_q <= PRESC_W'(wdata);
      if (addr == ADDR_INV_LO || addr == ADDR_INV_HI)
        inv_q <= NCH'(set_byte(16'(inv_q), addr[0], wdata));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pwm_fade_channel #(.PWM_W(PWM_W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_lo    (wr_lo[g]),
      .wr_hi    (wr_hi[g]),
      .wdata    (wdata),
      .boundary (boundary),
      .step     (step),
      .fade_en  (fade_en),
      .en       (ctrl_q[CTRL_EN]),
      .inv      (inv_q[g]),
      .ctr      (ctr),
      .pwm      (pwm_o[g]),
      .tgt      (tgt_arr[g]),
      .cur      (cur_arr[g])
    );
  end

  always_comb begin
    rdata = 8'h00;
    for (int i = 0; i < NCH; i++) begin
      if (addr[4:0] == 5'(i)) begin
        if (addr[7:5] == ADDR_TGT_LO[7:5])
          rdata = get_byte(16'(tgt_arr[i]), 1'b0);
        else if (PWM_W > 8 && addr[7:5] == ADDR_TGT_HI[7:5])
          rdata = get_byte(16'(tgt_arr[i]), 1'b1);
        else if (addr[7:5] == ADDR_CUR[7:5])
          rdata = get_byte(16'(cur_arr[i]), 1'b0);
      end
    end
    if (addr == ADDR_CTRL)
      rdata = {6'b0, ctrl_q};
    else if (addr == ADDR_PRESC)
      rdata = 8'(presc_q);
    else if (addr == ADDR_INV_LO || addr == ADDR_INV_HI)
      rdata = get_byte(16'(inv_q), addr[0]);
  end

endmodule

// File: tb/tb_pwm_fade_bank.sv
// Directed self-checking bench for pwm_fade_bank with the default 8-channel,
// 8-bit configuration (255-cycle period).
module tb_pwm_fade_bank;

  localparam int NCH     = 8;
  localparam int PWM_W   = 8;
  localparam int PRESC_W = 8;
  localparam int PERIOD  = 255;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           wen;
  logic [7:0]     addr;
  logic [7:0]     wdata;
  logic [7:0]     rdata;
  logic [NCH-1:0] pwm_o;
  logic           period_start;

  int         checks = 0;
  int         errors = 0;
  int         hi_cnt [NCH];
  int         ps_cnt;
  int         last_wait;
  logic [7:0] rd;

  pwm_fade_bank #(.NCH(NCH), .PWM_W(PWM_W), .PRESC_W(PRESC_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wen          (wen),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .pwm_o        (pwm_o),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    @(negedge clk);
    wen   = 1'b0;
  endtask

  task automatic readReg(input logic [7:0] a, output logic [7:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic waitPeriodStart(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!period_start && waited < 600);
    checkOutput("period_start_seen", 32'(period_start), 32'd1);
  endtask

  // Counts high cycles per channel over one full period starting at the pulse;
  // optionally issues one register write at sample wr_at.
  task automatic measurePeriod(input int wr_at, input logic [7:0] wa, input logic [7:0] wd);
    waitPeriodStart(last_wait);
    for (int c = 0; c < NCH; c++) hi_cnt[c] = 0;
    ps_cnt = 0;
    for (int s = 0; s < PERIOD; s++) begin
      if (s > 0) @(negedge clk);
      for (int c = 0; c < NCH; c++) hi_cnt[c] += int'(pwm_o[c]);
      ps_cnt += int'(period_start);
      if (s == wr_at) begin
        addr  = wa;
        wdata = wd;
        wen   = 1'b1;
      end else begin
        wen = 1'b0;
      end
    end
    wen = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    wen   = 1'b0;
    addr  = 8'h00;
    wdata = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_pwm_o", 32'(pwm_o), 32'd0);
    checkOutput("reset_period_start", 32'(period_start), 32'd0);
    readReg(8'h00, rd); checkOutput("reset_tgt0", 32'(rd), 32'h00);
    readReg(8'h60, rd); checkOutput("reset_ctrl", 32'(rd), 32'h00);
    readReg(8'h61, rd); checkOutput("reset_presc", 32'(rd), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic duty, plus both duty extremes on channels 1 and 2.
    applyStimulus(8'h60, 8'h01);
    applyStimulus(8'h00, 8'h40);
    applyStimulus(8'h01, 8'hFF);
    applyStimulus(8'h02, 8'h00);
    readReg(8'h00, rd); checkOutput("tgt0_readback", 32'(rd), 32'h40);
    readReg(8'h01, rd); checkOutput("tgt1_readback", 32'(rd), 32'hFF);
    for (int p = 0; p < 3; p++) begin
      measurePeriod(-1, 8'h00, 8'h00);
      checkOutput($sformatf("p%0d_ch0_high", p), 32'(hi_cnt[0]), 32'd64);
      checkOutput($sformatf("p%0d_ch1_high", p), 32'(hi_cnt[1]), 32'd255);
      checkOutput($sformatf("p%0d_ch2_high", p), 32'(hi_cnt[2]), 32'd0);
      checkOutput($sformatf("p%0d_ps_pulses", p), 32'(ps_cnt), 32'd1);
      if (p > 0) checkOutput($sformatf("p%0d_ps_spacing", p), 32'(last_wait), 32'd1);
    end
    readReg(8'h40, rd); checkOutput("cur0_readback", 32'(rd), 32'h40);

    // Mid-period target change applies only from the next period.
    measurePeriod(100, 8'h00, 8'h80);
    checkOutput("midchange_old_period", 32'(hi_cnt[0]), 32'd64);
    measurePeriod(-1, 8'h00, 8'h00);
    checkOutput("midchange_new_period", 32'(hi_cnt[0]), 32'd128);
    checkOutput("midchange_ps_spacing", 32'(last_wait), 32'd1);

    // Fade: PRESC=2 gives one LSB step every three periods.
    waitPeriodStart(last_wait);
    applyStimulus(8'h60, 8'h03);
    applyStimulus(8'h61, 8'h02);
    applyStimulus(8'h03, 8'h05);
    readReg(8'h61, rd); checkOutput("presc_readback", 32'(rd), 32'h02);
    readReg(8'h60, rd); checkOutput("ctrl_readback", 32'(rd), 32'h03);
    for (int j = 1; j <= 18; j++) begin
      waitPeriodStart(last_wait);
      readReg(8'h43, rd);
      checkOutput($sformatf("fade_cur3_b%0d", j), 32'(rd), ((j / 3) > 5) ? 32'd5 : 32'(j / 3));
    end

    // Start fading down, then clear FADE_EN before the next step is due.
    applyStimulus(8'h03, 8'h00);
    waitPeriodStart(last_wait);
    readReg(8'h43, rd); checkOutput("fade_down_hold", 32'(rd), 32'h05);
    applyStimulus(8'h60, 8'h01);
    applyStimulus(8'h00, 8'h10);
    applyStimulus(8'h62, 8'h01);
    applyStimulus(8'h63, 8'hFF);
    readReg(8'h62, rd); checkOutput("inv_lo_readback", 32'(rd), 32'h01);
    readReg(8'h63, rd); checkOutput("inv_hi_ignored", 32'(rd), 32'h00);
    measurePeriod(-1, 8'h00, 8'h00);
    checkOutput("inv_ch0_high", 32'(hi_cnt[0]), 32'd239);
    checkOutput("inv_ch1_high", 32'(hi_cnt[1]), 32'd255);
    checkOutput("snap_ch3_high", 32'(hi_cnt[3]), 32'd0);
    readReg(8'h43, rd); checkOutput("snap_cur3", 32'(rd), 32'h00);

    // Clearing EN forces all outputs low from the following cycle.
    @(negedge clk);
    checkOutput("en_before_clear_ch1", 32'(pwm_o[1]), 32'd1);
    applyStimulus(8'h60, 8'h00);
    @(negedge clk);
    checkOutput("en_cleared_pwm", 32'(pwm_o), 32'd0);
    @(negedge clk);
    checkOutput("en_cleared_pwm_hold", 32'(pwm_o), 32'd0);

    // Asynchronous reset in the middle of a fade.
    applyStimulus(8'h60, 8'h03);
    applyStimulus(8'h03, 8'h05);
    waitPeriodStart(last_wait);
    checkOutput("pre_reset_ch1", 32'(pwm_o[1]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_pwm", 32'(pwm_o), 32'd0);
    checkOutput("async_reset_ps", 32'(period_start), 32'd0);
    readReg(8'h00, rd); checkOutput("async_reset_tgt0", 32'(rd), 32'h00);
    readReg(8'h40, rd); checkOutput("async_reset_cur0", 32'(rd), 32'h00);
    readReg(8'h43, rd); checkOutput("async_reset_cur3", 32'(rd), 32'h00);
    readReg(8'h60, rd); checkOutput("async_reset_ctrl", 32'(rd), 32'h00);
    readReg(8'h7F, rd); checkOutput("unmapped_7f", 32'(rd), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("restart_period_start", 32'(period_start), 32'd1);
    checkOutput("restart_pwm", 32'(pwm_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
